// File: rtl/axi_burst_rd_slave_if.sv
// axi_burst_rd_slave_if: AXI read address and read data channel bundle
interface axi_burst_rd_slave_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_burst_rd_slave.sv
// axi_burst_rd_slave: one-burst-at-a-time AXI read slave over a 32-bit word array
module axi_burst_rd_slave #(
   parameter int    MEM_WORDS = 16384,
   parameter int    LATENCY   = 2,
   parameter string INIT_FILE = ""
) (
   input logic                 clk,
   input logic                 reset,
   axi_burst_rd_slave_if.slave bus
);
   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
   typedef enum logic [1:0] {FIXED, INCR, WRAP} kind_t;
   state_t      state, state_nxt;
   kind_t       kind;
   logic [31:0] mem [MEM_WORDS];
   logic [31:0] addr, addr_nxt, mask;
   logic [7:0]  len, beat;
   logic [3:0]  id, cnt;
   logic        err, slverr, wrap_ok, hs, present, done;

   assign hs       = bus.arvalid && bus.arready;
   assign wrap_ok  = bus.arlen inside {8'd1, 8'd3, 8'd7, 8'd15};
   assign mask     = {22'd0, len, 2'b11};
   assign slverr   = err || ((addr >> 2) >= 32'(MEM_WORDS));
   assign addr_nxt = (kind == FIXED) ? addr :
                     (kind == WRAP)  ? ((addr & ~mask) | ((addr + 32'd4) & mask)) :
                                       addr + 32'd4;

   // state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nxt;

   // next state plus beat-present and burst-done strobes
   always_comb begin
      state_nxt = state;
      present   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (hs) state_nxt = (LATENCY == 0) ? BURST : WAIT;
         WAIT:  if (cnt <= 4'd1) state_nxt = BURST;
         BURST: begin
            done    = bus.rvalid && bus.rready && bus.rlast;
            present = !bus.rvalid || (bus.rready && !bus.rlast);
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // request capture, latency count and registered beat outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.arready <= 1'b0;
         bus.rvalid  <= 1'b0;
         bus.rlast   <= 1'b0;
         bus.rdata   <= '0;
         bus.rid     <= '0;
         bus.rresp   <= '0;
      end else begin
         bus.arready <= state_nxt == IDLE;
         if (state == IDLE && hs) begin
            id   <= bus.arid;
            addr <= bus.araddr;
            len  <= bus.arlen;
            beat <= '0;
            cnt  <= 4'(LATENCY);
            err  <= (bus.arsize != 3'd2) || (bus.arburst == 2'b11) || ((bus.arburst == 2'b10) && !wrap_ok);
            kind <= (bus.arburst == 2'b00) ? FIXED : ((bus.arburst == 2'b10) && wrap_ok) ? WRAP : INCR;
         end
         if (state == WAIT) cnt <= cnt - 4'd1;
         if (done) begin
            bus.rvalid <= 1'b0;
            bus.rlast  <= 1'b0;
         end
         if (present) begin
            bus.rvalid <= 1'b1;
            bus.rid    <= id;
            bus.rlast  <= beat == len;
            bus.rresp  <= slverr ? 2'b10 : 2'b00;
            bus.rdata  <= slverr ? 32'd0 : mem[addr[AW+1:2]];
            addr       <= addr_nxt;
            beat       <= beat + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_axi_burst_rd_slave.sv
// tb_axi_burst_rd_slave: directed and randomized bursts checked against a behavioural model
module tb_axi_burst_rd_slave;
   localparam int MW  = 16384;
   localparam int LAT = 2;
   typedef struct {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} beat_t;
   logic   clk = 1'b0, reset = 1'b1;
   int     checks = 0, errors = 0, cyc = 0, hs_cnt = 0, hs_cyc = 0, cd = 0;
   beat_t  q[$], got[$];
   logic   m_arready = 1'b0, m_rvalid = 1'b0, m_rst = 1'b0, busy = 1'b0;

   axi_burst_rd_slave_if bus();
   axi_burst_rd_slave #(.MEM_WORDS(MW), .LATENCY(LAT), .INIT_FILE("")) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // byte address of beat k, from the burst rules stated as plain arithmetic
   function automatic logic [31:0] beat_addr(input logic [31:0] a0, input logic [7:0] len, input logic [1:0] bt, input int k);
      logic [31:0] a, size, base;
      logic wrap;
      wrap = (bt == 2'b10) && (len inside {8'd1, 8'd3, 8'd7, 8'd15});
      size = (32'(len) + 32'd1) * 32'd4;
      base = a0 - (a0 % size);
      a = a0;
      for (int i = 0; i < k; i++)
         a = (bt == 2'b00) ? a : wrap ? base + ((a - base + 32'd4) % size) : a + 32'd4;
      return a;
   endfunction

   task automatic model_ar(input logic [3:0] id, input logic [31:0] a0, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
      logic err, bad;
      logic [31:0] w;
      err = (sz != 3'd2) || (bt == 2'b11) || ((bt == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
      for (int k = 0; k <= int'(len); k++) begin
         w = beat_addr(a0, len, bt, k) >> 2;
         bad = err || (w >= 32'(MW));
         q.push_back('{id, bad ? 32'd0 : 32'hA000_0000 + w, bad ? 2'b10 : 2'b00, k == int'(len)});
      end
   endtask

   // model update and DUT beat/handshake collection at each rising edge
   always @(posedge clk) begin
      cyc++;
      if (!reset && bus.arvalid && bus.arready) begin
         hs_cnt++;
         hs_cyc = cyc;
      end
      if (!reset && bus.rvalid && bus.rready) got.push_back('{bus.rid, bus.rdata, bus.rresp, bus.rlast});
      m_rst = reset;
      if (reset) begin
         q.delete();
         busy = 1'b0;
         m_arready = 1'b0;
         m_rvalid = 1'b0;
      end else if (m_arready && bus.arvalid) begin
         model_ar(bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst);
         busy = 1'b1;
         m_arready = 1'b0;
         cd = LAT + 1;
      end else if (m_rvalid && bus.rready) begin
         if (q[0].last) begin
            busy = 1'b0;
            m_rvalid = 1'b0;
            m_arready = 1'b1;
         end
         void'(q.pop_front());
      end else if (busy && !m_rvalid) begin
         cd--;
         if (cd == 0) m_rvalid = 1'b1;
      end else if (!busy) m_arready = 1'b1;
   end

   // cycle-by-cycle comparison of DUT outputs with the model
   always @(negedge clk) begin
      chk("arready", 32'(bus.arready), 32'(m_arready));
      chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
      if (m_rst) begin
         chk("rst_rdata", bus.rdata, 32'd0);
         chk("rst_rid", 32'(bus.rid), 32'd0);
         chk("rst_rresp", 32'(bus.rresp), 32'd0);
         chk("rst_rlast", 32'(bus.rlast), 32'd0);
      end else if (m_rvalid) begin
         chk("rid", 32'(bus.rid), 32'(q[0].id));
         chk("rdata", bus.rdata, q[0].data);
         chk("rresp", 32'(bus.rresp), 32'(q[0].resp));
         chk("rlast", 32'(bus.rlast), 32'(q[0].last));
      end
   end

   task automatic burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                        input logic [1:0] bt, input bit pat, input bit hold, input int stop, output int first);
      int h0, j;
      h0 = hs_cnt;
      j = 0;
      got.delete();
      first = -1;
      bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = sz; bus.arburst = bt;
      bus.arvalid = 1'b1;
      bus.rready = 1'b1;
      while (j < 400 && got.size() < stop) begin
         @(negedge clk);
         if (hs_cnt != h0 && !hold) bus.arvalid = 1'b0;
         if (bus.rvalid && first < 0) first = cyc;
         j++;
         bus.rready = !pat || (j % 3 == 0);
      end
      chk("burst_done", 32'(got.size()), 32'(stop));
      bus.arvalid = 1'b0;
   endtask

   task automatic chk_beats(input string name, input logic [31:0] exp[$], input logic [15:0] errmask, input logic [3:0] id);
      chk({name, "_count"}, 32'(got.size()), 32'(exp.size()));
      for (int k = 0; k < exp.size() && k < got.size(); k++) begin
         chk({name, "_data"}, got[k].data, exp[k]);
         chk({name, "_resp"}, 32'(got[k].resp), errmask[k] ? 32'd2 : 32'd0);
         chk({name, "_last"}, 32'(got[k].last), 32'(k == exp.size() - 1));
         chk({name, "_id"}, 32'(got[k].id), 32'(id));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got cycle %0d want finish", cyc);
      $fatal(1, "timeout");
   end

   // directed scenarios, then randomized traffic
   initial begin
      logic [31:0] e[$];
      int first, h;
      bus.arvalid = 1'b0; bus.rready = 1'b0; bus.arid = '0; bus.araddr = '0;
      bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'b01;
      for (int i = 0; i < MW; i++) dut.mem[i] = 32'hA000_0000 + 32'(i);
      chk("pin_wrap_b2", beat_addr(32'h18, 8'd7, 2'b10, 2), 32'h0);
      chk("pin_wrap_b7", beat_addr(32'h18, 8'd7, 2'b10, 7), 32'h14);
      chk("pin_incr_b3", beat_addr(32'h100, 8'd3, 2'b01, 3), 32'h10C);
      chk("pin_fixed_b3", beat_addr(32'h100, 8'd3, 2'b00, 3), 32'h100);
      chk("pin_badwrap_b2", beat_addr(32'h18, 8'd2, 2'b10, 2), 32'h20);
      repeat (3) @(negedge clk);
      chk("rst_arready_lit", 32'(bus.arready), 32'd0);
      reset = 1'b0;
      chk("release_arready", 32'(bus.arready), 32'd0);
      @(negedge clk);
      chk("first_arready", 32'(bus.arready), 32'd1);
      h = hs_cnt;
      burst(4'h3, 32'h18, 8'd7, 3'd2, 2'b10, 1'b0, 1'b1, 8, first);
      e = '{32'hA000_0006, 32'hA000_0007, 32'hA000_0000, 32'hA000_0001,
            32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 32'hA000_0005};
      chk_beats("wrap8", e, 16'h0, 4'h3);
      chk("first_rvalid_cycle", 32'(first), 32'(hs_cyc + 3));
      chk("single_accept", 32'(hs_cnt - h), 32'd1);
      chk("wrap8_arready_after", 32'(bus.arready), 32'd1);
      burst(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1, 1'b0, 4, first);
      e = '{32'hA000_0040, 32'hA000_0041, 32'hA000_0042, 32'hA000_0043};
      chk_beats("incr_stall", e, 16'h0, 4'h5);
      chk("incr_arready_after", 32'(bus.arready), 32'd1);
      burst(4'h1, 32'((MW - 1) * 4), 8'd1, 3'd2, 2'b01, 1'b0, 1'b0, 2, first);
      e = '{32'hA000_3FFF, 32'h0};
      chk_beats("edge", e, 16'h2, 4'h1);
      e = '{32'h0, 32'h0, 32'h0, 32'h0};
      burst(4'h2, 32'h40, 8'd3, 3'd1, 2'b01, 1'b0, 1'b0, 4, first);
      chk_beats("size1", e, 16'hF, 4'h2);
      burst(4'h4, 32'h40, 8'd3, 3'd2, 2'b11, 1'b0, 1'b0, 4, first);
      chk_beats("rsvd", e, 16'hF, 4'h4);
      e = '{32'h0, 32'h0, 32'h0};
      burst(4'h6, 32'h18, 8'd2, 3'd2, 2'b10, 1'b0, 1'b0, 3, first);
      chk_beats("badwrap", e, 16'h7, 4'h6);
      burst(4'h3, 32'h18, 8'd7, 3'd2, 2'b10, 1'b0, 1'b0, 3, first);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_rvalid", 32'(bus.rvalid), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_arready", 32'(bus.arready), 32'd1);
      repeat (4) @(negedge clk);
      chk("abort_no_residual", 32'(got.size()), 32'd3);
      burst(4'h3, 32'h18, 8'd7, 3'd2, 2'b10, 1'b0, 1'b0, 8, first);
      e = '{32'hA000_0006, 32'hA000_0007, 32'hA000_0000, 32'hA000_0001,
            32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 32'hA000_0005};
      chk_beats("wrap8_again", e, 16'h0, 4'h3);
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         reset = $urandom_range(0, 599) == 0;
         bus.arvalid = $urandom_range(0, 2) != 0;
         bus.arid = 4'($urandom);
         case ($urandom_range(0, 3))
            0: bus.araddr = 32'((MW - 4 + int'($urandom_range(0, 7))) * 4) | 32'($urandom_range(0, 3));
            1: bus.araddr = $urandom;
            default: bus.araddr = 32'($urandom_range(0, MW * 4 - 1));
         endcase
         bus.arlen = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         bus.arsize = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2;
         bus.arburst = 2'($urandom);
         bus.rready = $urandom_range(0, 3) != 0;
      end
      @(negedge clk);
      reset = 1'b0;
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      for (int n = 0; n < 2000 && busy; n++) @(negedge clk);
      chk("drain_idle", 32'(busy), 32'd0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
